// File: rtl/snes_poll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : snes_poll_ctrl
//  Brief    : Host-side SNES/NES controller poll engine (latch, serial clock,
//             16-bit capture) with manual and periodic triggering.
//  Revision : 1.0
// ============================================================================
module snes_poll_ctrl #(
    parameter int CLK_DIV     = 72,
    parameter int LATCH_LEN   = 144,
    parameter int POLL_PERIOD = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        auto_en,
    input  logic        snes_data,
    output logic        snes_latch,
    output logic        snes_clock,
    output logic [15:0] buttons,
    output logic        valid,
    output logic        busy,
    output logic        overrun
);

    localparam int c_PH_MAX  = (CLK_DIV > LATCH_LEN) ? CLK_DIV : LATCH_LEN;
    localparam int c_PH_W    = $clog2(c_PH_MAX);
    localparam int c_PER_W   = $clog2(POLL_PERIOD);

    localparam logic [c_PH_W-1:0]  c_LATCH_LAST = c_PH_W'(LATCH_LEN - 1);
    localparam logic [c_PH_W-1:0]  c_DIV_LAST   = c_PH_W'(CLK_DIV - 1);
    localparam logic [c_PH_W-1:0]  c_PH_ONE     = c_PH_W'(1);
    localparam logic [c_PER_W-1:0] c_PER_LAST   = c_PER_W'(POLL_PERIOD - 1);
    localparam logic [c_PER_W-1:0] c_PER_ONE    = c_PER_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_CLK_LO = 3'd2,
        S_CLK_HI = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [c_PH_W-1:0]    ph_cnt_q, ph_cnt_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [15:0]          shift_q, shift_d;
    logic [c_PER_W-1:0]   per_cnt_q, per_cnt_d;
    logic [1:0]           sync_q;
    logic                 latch_q, latch_d;
    logic                 sclk_q, sclk_d;
    logic [15:0]          buttons_q, buttons_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic                 w_tick;

    // Period timer: the tick coincides with the wrap back to zero.
    assign w_tick = auto_en && (per_cnt_q == c_PER_LAST);

    always_comb begin
        per_cnt_d = per_cnt_q;
        if (!auto_en || w_tick) begin
            per_cnt_d = '0;
        end else begin
            per_cnt_d = per_cnt_q + c_PER_ONE;
        end
    end

    always_comb begin
        state_d   = state_q;
        ph_cnt_d  = ph_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        overrun_d = overrun_q | (w_tick && (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (start || w_tick) begin
                    state_d   = S_LATCH;
                    ph_cnt_d  = '0;
                    bit_idx_d = 4'd0;
                    shift_d   = 16'h0000;
                end
            end
            S_LATCH: begin
                if (ph_cnt_q == c_LATCH_LAST) begin
                    state_d  = S_CLK_LO;
                    ph_cnt_d = '0;
                end else begin
                    ph_cnt_d = ph_cnt_q + c_PH_ONE;
                end
            end
            S_CLK_LO: begin
                if (ph_cnt_q == c_DIV_LAST) begin
                    // Sample just before the controller shifts on the rising edge.
                    shift_d[bit_idx_q] = ~sync_q[1];
                    state_d            = S_CLK_HI;
                    ph_cnt_d           = '0;
                end else begin
                    ph_cnt_d = ph_cnt_q + c_PH_ONE;
                end
            end
            S_CLK_HI: begin
                if (ph_cnt_q == c_DIV_LAST) begin
                    ph_cnt_d = '0;
                    if (bit_idx_q == 4'd15) begin
                        state_d = S_DONE;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        state_d   = S_CLK_LO;
                    end
                end else begin
                    ph_cnt_d = ph_cnt_q + c_PH_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_comb begin
        latch_d   = (state_d == S_LATCH);
        sclk_d    = (state_d != S_CLK_LO);
        valid_d   = (state_d == S_DONE);
        busy_d    = (state_d != S_IDLE);
        buttons_d = (state_d == S_DONE) ? shift_q : buttons_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ph_cnt_q  <= '0;
            bit_idx_q <= 4'd0;
            shift_q   <= 16'h0000;
            per_cnt_q <= '0;
            sync_q    <= 2'b11;
            latch_q   <= 1'b0;
            sclk_q    <= 1'b1;
            buttons_q <= 16'h0000;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_cnt_q  <= ph_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            per_cnt_q <= per_cnt_d;
            sync_q    <= {sync_q[0], snes_data};
            latch_q   <= latch_d;
            sclk_q    <= sclk_d;
            buttons_q <= buttons_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign snes_latch = latch_q;
    assign snes_clock = sclk_q;
    assign buttons    = buttons_q;
    assign valid      = valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_snes_poll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snes_poll_ctrl
//  Brief    : Directed self-checking bench for snes_poll_ctrl with a
//             behavioural controller shifter model.
//  Revision : 1.0
// ============================================================================
module tb_snes_poll_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        auto_en;
    logic        snes_data;
    logic        snes_latch;
    logic        snes_clock;
    logic [15:0] buttons;
    logic        valid;
    logic        busy;
    logic        overrun;

    logic        start_ov;
    logic        auto_ov;
    logic        data_ov;
    logic        latch_ov;
    logic        sclk_ov;
    logic [15:0] buttons_ov;
    logic        valid_ov;
    logic        busy_ov;
    logic        overrun_ov;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    snes_poll_ctrl #(.CLK_DIV(4), .LATCH_LEN(8), .POLL_PERIOD(400)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .auto_en    (auto_en),
        .snes_data  (snes_data),
        .snes_latch (snes_latch),
        .snes_clock (snes_clock),
        .buttons    (buttons),
        .valid      (valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    snes_poll_ctrl #(.CLK_DIV(4), .LATCH_LEN(8), .POLL_PERIOD(100)) dut_ov (
        .clk        (clk),
        .reset      (reset),
        .start      (start_ov),
        .auto_en    (auto_ov),
        .snes_data  (data_ov),
        .snes_latch (latch_ov),
        .snes_clock (sclk_ov),
        .buttons    (buttons_ov),
        .valid      (valid_ov),
        .busy       (busy_ov),
        .overrun    (overrun_ov)
    );

    // Controller model: reload while latched, shift on serial-clock rise.
    logic [15:0] mask;
    logic [15:0] sr        = 16'hFFFF;
    logic        prev_sclk = 1'b1;
    logic [1:0]  dmode;

    always @(posedge clk) begin
        prev_sclk <= snes_clock;
        if (snes_latch)
            sr <= ~mask;
        else if (snes_clock && !prev_sclk)
            sr <= {1'b1, sr[15:1]};
    end

    assign snes_data = (dmode == 2'd0) ? sr[0] : ((dmode == 2'd1) ? 1'b1 : 1'b0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic poll_word(input logic [15:0] m, input logic [15:0] exp, input string tag);
        logic got;
        mask  = m;
        start = 1'b1;
        got   = 1'b0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (valid) got = 1'b1;
        end
        chk({tag, "_valid"}, 32'(got), 32'd1);
        chk(tag, 32'(buttons), 32'(exp));
        @(posedge clk); #1;
    endtask

    int lat_first, lat_cnt, first_low, falls, low_cyc, vn, vcnt;
    logic [15:0] vbtn, lastbtn;
    logic busy1, busy138, prev_s, prev_l, ovs, ov_a, ov_b;
    int lrise, vc, vfirst, vlast, bad, vc2, vfirst2;

    initial begin
        reset = 1'b0; start = 1'b0; auto_en = 1'b0; mask = 16'h0000; dmode = 2'd0;
        start_ov = 1'b0; auto_ov = 1'b0; data_ov = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_latch",   32'(snes_latch), 32'd0);
        chk("rst_sclk",    32'(snes_clock), 32'd1);
        chk("rst_buttons", 32'(buttons),    32'd0);
        chk("rst_valid",   32'(valid),      32'd0);
        chk("rst_busy",    32'(busy),       32'd0);
        chk("rst_overrun", 32'(overrun),    32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Single poll with full waveform timing
        mask = 16'hA5C3; start = 1'b1;
        lat_first = 0; lat_cnt = 0; first_low = 0; falls = 0; low_cyc = 0;
        vn = 0; vcnt = 0; vbtn = 16'h0; prev_s = 1'b1; busy1 = 1'b0; busy138 = 1'b1;
        for (int n = 1; n <= 160; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (n == 1)   busy1   = busy;
            if (n == 138) busy138 = busy;
            if (snes_latch) begin
                lat_cnt++;
                if (lat_first == 0) lat_first = n;
            end
            if (!snes_clock) begin
                low_cyc++;
                if (prev_s) falls++;
                if (first_low == 0) first_low = n;
            end
            prev_s = snes_clock;
            if (valid) begin
                vcnt++;
                if (vn == 0) begin vn = n; vbtn = buttons; end
            end
        end
        chk("sp_latch_first", 32'(lat_first), 32'd1);
        chk("sp_latch_len",   32'(lat_cnt),   32'd8);
        chk("sp_sclk_first",  32'(first_low), 32'd9);
        chk("sp_sclk_pulses", 32'(falls),     32'd16);
        chk("sp_sclk_low",    32'(low_cyc),   32'd64);
        chk("sp_valid_time",  32'(vn),        32'd137);
        chk("sp_valid_count", 32'(vcnt),      32'd1);
        chk("sp_buttons",     32'(vbtn),      32'hA5C3);
        chk("sp_busy_start",  32'(busy1),     32'd1);
        chk("sp_busy_drop",   32'(busy138),   32'd0);
        chk("sp_hold",        32'(buttons),   32'hA5C3);

        // Auto-poll, collision with start at the first tick, start re-pulsed mid-poll
        mask = 16'h3C5A;
        lrise = 0; vc = 0; vfirst = 0; vlast = 0; bad = 0; prev_l = 1'b0; ovs = 1'b0;
        lastbtn = 16'h0;
        for (int j = 0; j < 2200; j++) begin
            start   = (j == 399) || (j == 450);
            auto_en = (j < 2000);
            @(posedge clk); #1;
            if (snes_latch && !prev_l) lrise++;
            prev_l = snes_latch;
            if (valid) begin
                if (vc > 0 && (j - vlast) != 400) bad++;
                if (vc == 0) vfirst = j;
                vlast = j;
                vc++;
                lastbtn = buttons;
            end
            if (overrun) ovs = 1'b1;
        end
        start = 1'b0; auto_en = 1'b0;
        chk("ap_first_valid", 32'(vfirst),  32'd535);
        chk("ap_valid_count", 32'(vc),      32'd5);
        chk("ap_interval",    32'(bad),     32'd0);
        chk("ap_latch_count", 32'(lrise),   32'd5);
        chk("ap_overrun",     32'(ovs),     32'd0);
        chk("ap_buttons",     32'(lastbtn), 32'h3C5A);

        // Overrun with a period shorter than a poll
        vc2 = 0; vfirst2 = 0; ov_a = 1'b1; ov_b = 1'b0;
        for (int j = 0; j < 1000; j++) begin
            auto_ov = 1'b1;
            @(posedge clk); #1;
            if (j == 198) ov_a = overrun_ov;
            if (j == 199) ov_b = overrun_ov;
            if (valid_ov) begin
                if (vc2 == 0) vfirst2 = j;
                vc2++;
            end
        end
        chk("ov_before",      32'(ov_a),       32'd0);
        chk("ov_set",         32'(ov_b),       32'd1);
        chk("ov_sticky",      32'(overrun_ov), 32'd1);
        chk("ov_first_valid", 32'(vfirst2),    32'd235);
        chk("ov_valid_count", 32'(vc2),        32'd4);
        auto_ov = 1'b0;

        // Reset during the low phase of bit 7
        mask = 16'h0F0F; start = 1'b1;
        for (int n = 1; n <= 66; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("mr_in_clk_lo", 32'(snes_clock), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mr_latch",   32'(snes_latch), 32'd0);
        chk("mr_sclk",    32'(snes_clock), 32'd1);
        chk("mr_buttons", 32'(buttons),    32'd0);
        chk("mr_busy",    32'(busy),       32'd0);
        chk("mr_valid",   32'(valid),      32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        poll_word(16'h1234, 16'h1234, "post_rst");

        dmode = 2'd1;
        poll_word(16'h5555, 16'h0000, "none_pressed");
        dmode = 2'd2;
        poll_word(16'h5555, 16'hFFFF, "all_pressed");
        dmode = 2'd0;
        poll_word(16'h8001, 16'h8001, "edge_bits");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
